// File: rtl/dec_pkg.sv
// dec_pkg: default widths and width helpers shared by the decimator controller,
// the branch FIR wrappers and the testbench.
package dec_pkg;
    localparam int NUM_BRANCH = 4;
    localparam int WORD_IN = 8;
    localparam int WORD_BR = 20;
    localparam int WORD_OUT = 20;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int word_sum(input int word_br, input int num_branch);
        return word_br + clog2(num_branch);
    endfunction
    localparam int WORD_SUM = word_sum(WORD_BR, NUM_BRANCH);
endpackage

// File: rtl/polyphase_dec_ctrl_if.sv
// polyphase_dec_ctrl_if: input sample stream and decimated output stream handshakes.
interface polyphase_dec_ctrl_if #(
    parameter int WORD_IN = dec_pkg::WORD_IN,
    parameter int WORD_OUT = dec_pkg::WORD_OUT
);
    logic in_valid;
    logic in_ready;
    logic [WORD_IN-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [WORD_OUT-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/polyphase_commutator.sv
// polyphase_commutator: phase down-counter that steers each accepted sample to one branch.
module polyphase_commutator import dec_pkg::*; #(
    parameter int NUM_BRANCH = dec_pkg::NUM_BRANCH,
    parameter int WORD_IN = dec_pkg::WORD_IN,
    localparam int PW = clog2(NUM_BRANCH)
) (
    input logic clk,
    input logic reset,
    input logic accept,
    input logic flush,
    input logic [WORD_IN-1:0] in_data,
    output logic [PW-1:0] phase,
    output logic [NUM_BRANCH-1:0] br_en,
    output logic [WORD_IN-1:0] br_x
);
    localparam logic [PW-1:0] LAST = PW'(NUM_BRANCH - 1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= LAST;
            br_en <= '0;
            br_x <= '0;
        end else begin
            phase <= flush ? LAST : !accept ? phase : phase == '0 ? LAST : phase - PW'(1);
            br_en <= accept ? NUM_BRANCH'(1) << phase : '0;
            if (accept) br_x <= in_data;
        end
    end
endmodule

// File: rtl/polyphase_dec_ctrl.sv
// polyphase_dec_ctrl: commutates samples across M branch filters, sums each frame, emits one
// decimated sample. Define DEC_SAT_EN to saturate the output and expose the sticky sat_flag.
module polyphase_dec_ctrl import dec_pkg::*; #(
    parameter int NUM_BRANCH = dec_pkg::NUM_BRANCH,
    parameter int WORD_IN = dec_pkg::WORD_IN,
    parameter int WORD_BR = dec_pkg::WORD_BR,
    parameter int WORD_OUT = dec_pkg::WORD_OUT,
    localparam int PW = clog2(NUM_BRANCH)
) (
    input logic clk,
    input logic reset,
    input logic flush,
    polyphase_dec_ctrl_if.slave bus,
    output logic [NUM_BRANCH-1:0] br_en,
    output logic [WORD_IN-1:0] br_x,
    input logic [NUM_BRANCH*WORD_BR-1:0] br_y,
    output logic [PW-1:0] phase
`ifdef DEC_SAT_EN
    ,
    output logic sat_flag
`endif
);
    localparam int WORD_SUM = word_sum(WORD_BR, NUM_BRANCH);
    localparam int WX = WORD_SUM > WORD_OUT ? WORD_SUM : WORD_OUT;
    logic accept, pend0, s2, load;
    logic [PW-1:0] en_idx, s2_idx;
    logic signed [WORD_SUM-1:0] acc, sum;
    logic signed [WX-1:0] sx;
    logic [WORD_OUT-1:0] res;

    assign bus.in_ready = reset & ~flush & ~pend0 & ~(bus.out_valid & ~bus.out_ready);
    assign accept = bus.in_valid & bus.in_ready;

    polyphase_commutator #(.NUM_BRANCH(NUM_BRANCH), .WORD_IN(WORD_IN)) u_comm (
        .clk,
        .reset,
        .accept,
        .flush,
        .in_data(bus.in_data),
        .phase,
        .br_en,
        .br_x
    );

    always_comb begin
        en_idx = '0;
        for (int i = 0; i < NUM_BRANCH; i++) if (br_en[i]) en_idx = PW'(i);
    end

    // the branch slice is valid one cycle after its enable, so its index is staged one edge
    assign sum = acc + WORD_SUM'(signed'(br_y[s2_idx*WORD_BR +: WORD_BR]));
    assign sx = WX'(sum);
    assign load = s2 & (s2_idx == '0) & ~flush;

`ifdef DEC_SAT_EN
    localparam logic signed [WX-1:0] HI = WX'({1'b0, {(WORD_OUT-1){1'b1}}});
    localparam logic signed [WX-1:0] LO = ~HI;
    logic clip;
    assign clip = sx > HI || sx < LO;
    assign res = sx > HI ? HI[WORD_OUT-1:0] : sx < LO ? LO[WORD_OUT-1:0] : sx[WORD_OUT-1:0];
    always_ff @(posedge clk) sat_flag <= !reset || flush ? 1'b0 : sat_flag | (load & clip);
`else
    assign res = sx[WORD_OUT-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend0 <= 1'b0;
            s2 <= 1'b0;
            s2_idx <= '0;
            acc <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
        end else begin
            pend0 <= flush ? 1'b0 : (accept && phase == '0) ? 1'b1 : load ? 1'b0 : pend0;
            s2 <= |br_en & ~flush;
            s2_idx <= en_idx;
            acc <= flush || load ? '0 : s2 ? sum : acc;
            bus.out_valid <= load | (bus.out_valid & ~bus.out_ready);
            if (load) bus.out_data <= res;
        end
    end
endmodule

// File: tb/tb_polyphase_dec_ctrl.sv
// tb_polyphase_dec_ctrl: scoreboard bench with a frame-level reference model and behavioural branches.
module tb_polyphase_dec_ctrl;
    import dec_pkg::*;
    localparam int NB = NUM_BRANCH;
    localparam int PW = clog2(NB);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [NB-1:0] br_en;
    logic [WORD_IN-1:0] br_x;
    logic [NB*WORD_BR-1:0] br_y;
    logic [PW-1:0] phase;
`ifdef DEC_SAT_EN
    logic sat_flag;
`endif

    polyphase_dec_ctrl_if #(.WORD_IN(WORD_IN), .WORD_OUT(WORD_OUT)) bus ();

    polyphase_dec_ctrl dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bus),
        .br_en(br_en),
        .br_x(br_x),
        .br_y(br_y),
        .phase(phase)
`ifdef DEC_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    // behavioural branches: constant per slice, or x*coef
    bit cmode = 1'b1;
    int cval [NB];
    int coef [NB];
    logic signed [WORD_BR-1:0] yv [NB];

    function automatic longint f(input logic [WORD_IN-1:0] x, input int p);
        return cmode ? longint'(cval[p]) : longint'(signed'(x)) * longint'(coef[p]);
    endfunction

    always @(posedge clk) for (int i = 0; i < NB; i++) if (br_en[i]) yv[i] <= WORD_BR'(f(br_x, i));
    always_comb for (int i = 0; i < NB; i++) br_y[i*WORD_BR +: WORD_BR] = yv[i];

    function automatic logic [WORD_OUT-1:0] fmt(input longint s, output bit c);
`ifdef DEC_SAT_EN
        longint hi = (longint'(1) <<< (WORD_OUT - 1)) - 1;
        c = s > hi || s < -hi - 1;
        return c ? (s > hi ? WORD_OUT'(hi) : WORD_OUT'(-hi - 1)) : WORD_OUT'(s);
`else
        c = 1'b0;
        return WORD_OUT'(s);
`endif
    endfunction

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model state
    logic [WORD_OUT-1:0] q [$];
    bit armed = 1'b0;
    int mphase = NB - 1;
    longint msum = 0;
    bit mvalid = 1'b0, a1 = 1'b0, a2 = 1'b0, c1 = 1'b0, c2 = 1'b0, msat = 1'b0, prst = 1'b1;
    logic [NB-1:0] men = '0;
    logic [WORD_IN-1:0] mbrx = '0;

    always @(negedge clk) if (armed) begin
        bit exp_rdy, acc, comp, c;
        exp_rdy = reset & ~flush & ~a1 & ~a2 & ~(mvalid & ~bus.out_ready);
        chk("phase", 64'(phase), 64'(mphase));
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(mvalid));
        chk("br_en", 64'(br_en), 64'(men));
        chk("br_x", 64'(br_x), 64'(mbrx));
`ifdef DEC_SAT_EN
        chk("sat_flag", 64'(sat_flag), 64'(msat));
`endif
        if (prst) chk("out_data_after_reset", 64'(bus.out_data), 64'd0);
        acc = bus.in_valid & exp_rdy;
        comp = reset & ~flush & a2;
        if (!reset) begin
            mphase = NB - 1;
            msum = 0;
            q.delete();
            {mvalid, a1, a2, c1, c2, msat} = '0;
            men = '0;
            mbrx = '0;
        end else begin
            if (flush && (a1 || a2)) void'(q.pop_back());
            if (comp) msat = msat | c2;
            if (flush) msat = 1'b0;
            mvalid = comp | (mvalid & ~bus.out_ready);
            men = acc ? NB'(1 << mphase) : '0;
            if (acc) mbrx = bus.in_data;
            a2 = flush ? 1'b0 : a1;
            c2 = c1;
            a1 = 1'b0;
            if (flush) begin
                mphase = NB - 1;
                msum = 0;
            end else if (acc) begin
                msum += f(bus.in_data, mphase);
                if (mphase == 0) begin
                    q.push_back(fmt(msum, c));
                    a1 = 1'b1;
                    c1 = c;
                    msum = 0;
                end
                mphase = mphase == 0 ? NB - 1 : mphase - 1;
            end
        end
        prst = !reset;
    end

    // monitor: every presented output must match the oldest expected frame
    always @(negedge clk) if (armed && reset && bus.out_valid) begin
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_unexpected: got %0d expected no output", bus.out_data);
        end else begin
            chk("out_data", 64'(bus.out_data), 64'(q[0]));
            if (bus.out_ready) void'(q.pop_front());
        end
    end

    task automatic drive(input bit v, input bit fl, input bit r, input bit ordy, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = v;
            bus.in_data = WORD_IN'($urandom);
            flush = fl;
            reset = r;
            bus.out_ready = ordy;
        end
    endtask

    task automatic drain();
        drive(0, 0, 1, 1, 6);
        drive(0, 1, 1, 1, 1);
    endtask

    task automatic set_const(input int base, input int step);
        for (int i = 0; i < NB; i++) cval[i] = base + step * i;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        set_const(100, 0);
        for (int i = 0; i < NB; i++) coef[i] = 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        armed = 1'b1;
        drive(1, 0, 1, 1, 40);
        drain();
        set_const(300000, 0);
        drive(1, 0, 1, 1, 12);
        drain();
        set_const(100, 0);
        drive(1, 0, 1, 1, 8);
        drive(1, 0, 1, 0, 10);
        drive(1, 0, 1, 1, 20);
        drain();
        set_const(1, 1);
        drive(1, 0, 1, 1, 2);
        drive(1, 1, 1, 1, 1);
        drive(1, 0, 1, 1, 12);
        drain();
        set_const(100, 0);
        drive(1, 0, 1, 1, 2);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 1, 1, 12);
        drain();
        cmode = 1'b0;
        for (int i = 0; i < NB; i++) coef[i] = int'($urandom_range(0, 8190)) - 4095;
        repeat (1500)
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, 1);
        drive(0, 0, 1, 1, 10);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
